// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use stall, branch flush
// and a data-memory wait/timeout FSM that freezes the whole pipeline.
module pipe_hazard_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNTW    = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      rs1d,
  input  logic [4:0]      rs2d,
  input  logic [4:0]      rs1e,
  input  logic [4:0]      rs2e,
  input  logic [4:0]      rde,
  input  logic [4:0]      rdm,
  input  logic [4:0]      rdw,
  input  logic            regwritem,
  input  logic            regwritew,
  input  logic            loade,
  input  logic            pcsrce,
  input  logic            dmem_req,
  input  logic            dmem_ack,
  output logic [1:0]      forwardae,
  output logic [1:0]      forwardbe,
  output logic            pc_en,
  output logic            ifd_en,
  output logic            ifd_clr,
  output logic            ide_clr,
  output logic            ex_en,
  output logic            mem_err,
  output logic [CNTW-1:0] stall_cnt
);

  localparam int unsigned WW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {RUN, WAIT, ERR} state_t;

  state_t        state, state_n;
  logic [WW-1:0] wcnt, wcnt_n;
  logic          lwstall;
  logic          freeze;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (regwritem && rdm != 5'd0 && rdm == rs)      fwd_sel = 2'b10;
    else if (regwritew && rdw != 5'd0 && rdw == rs) fwd_sel = 2'b01;
    else                                            fwd_sel = 2'b00;
  endfunction

  always_comb begin
    forwardae = fwd_sel(rs1e);
    forwardbe = fwd_sel(rs2e);
  end

  assign lwstall = loade && rde != 5'd0 && (rde == rs1d || rde == rs2d);

  // Freeze is decoded from the current state plus live handshake so it is
  // already asserted in the request cycle and released in the ack cycle.
  always_comb begin
    unique case (state)
      RUN:     freeze = dmem_req && !dmem_ack;
      WAIT:    freeze = !dmem_ack;
      default: freeze = 1'b1;
    endcase
  end

  always_comb begin
    state_n = state;
    wcnt_n  = wcnt;
    unique case (state)
      RUN: begin
        if (dmem_req && !dmem_ack) begin
          state_n = WAIT;
          wcnt_n  = '0;
        end
      end
      WAIT: begin
        if (dmem_ack) begin
          state_n = RUN;
          wcnt_n  = '0;
        end else if (wcnt == WW'(TIMEOUT)) begin
          state_n = ERR;
        end else begin
          wcnt_n = wcnt + 1'b1;
        end
      end
      default: state_n = ERR;
    endcase
  end

  always_comb begin
    pc_en   = 1'b1;
    ifd_en  = 1'b1;
    ex_en   = 1'b1;
    ifd_clr = 1'b0;
    ide_clr = 1'b0;
    if (freeze) begin
      pc_en  = 1'b0;
      ifd_en = 1'b0;
      ex_en  = 1'b0;
    end else if (pcsrce) begin
      ifd_clr = 1'b1;
      ide_clr = 1'b1;
    end else if (lwstall) begin
      pc_en   = 1'b0;
      ifd_en  = 1'b0;
      ide_clr = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      wcnt      <= '0;
      mem_err   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state   <= state_n;
      wcnt    <= wcnt_n;
      mem_err <= mem_err | (state_n == ERR);
      if (!ifd_en && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: combinational vector table plus
// hand-written multi-cycle sequences (memory wait, timeout, saturation).
module tb_pipe_hazard_ctrl;

  localparam int unsigned CW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
  logic          regwritem, regwritew, loade, pcsrce, dmem_req, dmem_ack;
  logic [1:0]    forwardae, forwardbe;
  logic          pc_en, ifd_en, ifd_clr, ide_clr, ex_en, mem_err;
  logic [CW-1:0] stall_cnt;

  int npass = 0;
  int ntotal = 0;

  pipe_hazard_ctrl #(.TIMEOUT(4), .CNTW(CW)) dut (
    .clk(clk), .reset(reset),
    .rs1d(rs1d), .rs2d(rs2d), .rs1e(rs1e), .rs2e(rs2e), .rde(rde),
    .rdm(rdm), .rdw(rdw), .regwritem(regwritem), .regwritew(regwritew),
    .loade(loade), .pcsrce(pcsrce), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .forwardae(forwardae), .forwardbe(forwardbe), .pc_en(pc_en),
    .ifd_en(ifd_en), .ifd_clr(ifd_clr), .ide_clr(ide_clr), .ex_en(ex_en),
    .mem_err(mem_err), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       rwm, rww, lde, br;
    logic [1:0] fae, fbe;
    logic       pce, ife, ifc, idc;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_ctl(input string name, input logic pce, input logic ife,
                         input logic exe, input logic ifc, input logic idc);
    chk({name, ".pc_en"},   32'(pc_en),   32'(pce));
    chk({name, ".ifd_en"},  32'(ifd_en),  32'(ife));
    chk({name, ".ex_en"},   32'(ex_en),   32'(exe));
    chk({name, ".ifd_clr"}, 32'(ifd_clr), 32'(ifc));
    chk({name, ".ide_clr"}, 32'(ide_clr), 32'(idc));
  endtask

  task automatic idle_inputs();
    rs1d = 5'd1; rs2d = 5'd2; rs1e = 5'd3; rs2e = 5'd4; rde = 5'd0;
    rdm = 5'd0; rdw = 5'd0; regwritem = 1'b0; regwritew = 1'b0;
    loade = 1'b0; pcsrce = 1'b0; dmem_req = 1'b0; dmem_ack = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    //        rs1d  rs2d  rs1e  rs2e  rde   rdm   rdw  rwm rww lde br  fae    fbe   pce ife ifc idc
    vt[0]  = '{5'd1, 5'd2, 5'd5, 5'd3, 5'd0, 5'd5, 5'd5, 1, 1, 0, 0, 2'b10, 2'b00, 1, 1, 0, 0};
    vt[1]  = '{5'd1, 5'd2, 5'd5, 5'd3, 5'd0, 5'd0, 5'd5, 1, 1, 0, 0, 2'b01, 2'b00, 1, 1, 0, 0};
    vt[2]  = '{5'd1, 5'd2, 5'd5, 5'd3, 5'd0, 5'd5, 5'd5, 0, 1, 0, 0, 2'b01, 2'b00, 1, 1, 0, 0};
    vt[3]  = '{5'd1, 5'd2, 5'd9, 5'd9, 5'd0, 5'd9, 5'd9, 1, 0, 0, 0, 2'b10, 2'b10, 1, 1, 0, 0};
    vt[4]  = '{5'd1, 5'd2, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1, 1, 0, 0, 2'b00, 2'b00, 1, 1, 0, 0};
    vt[5]  = '{5'd1, 5'd2, 5'd4, 5'd12, 5'd0, 5'd4, 5'd12, 1, 1, 0, 0, 2'b10, 2'b01, 1, 1, 0, 0};
    vt[6]  = '{5'd1, 5'd7, 5'd3, 5'd4, 5'd7, 5'd0, 5'd0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 1};
    vt[7]  = '{5'd7, 5'd2, 5'd3, 5'd4, 5'd7, 5'd0, 5'd0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 1};
    vt[8]  = '{5'd0, 5'd2, 5'd3, 5'd4, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 2'b00, 2'b00, 1, 1, 0, 0};
    vt[9]  = '{5'd7, 5'd2, 5'd3, 5'd4, 5'd7, 5'd0, 5'd0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 1, 0, 0};
    vt[10] = '{5'd1, 5'd7, 5'd3, 5'd4, 5'd7, 5'd0, 5'd0, 0, 0, 1, 1, 2'b00, 2'b00, 1, 1, 1, 1};
    vt[11] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 2'b00, 2'b00, 1, 1, 1, 1};

    idle_inputs();
    reset = 1'b1;

    // Reset state, with a load-use hazard present so ifd_en is low.
    loade = 1'b1; rde = 5'd7; rs2d = 5'd7;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.stall_cnt", 32'(stall_cnt), 32'd0);
    chk("rst.mem_err", 32'(mem_err), 32'd0);
    idle_inputs();
    #1;
    chk_ctl("rst", 1, 1, 1, 0, 0);
    @(negedge clk);
    reset = 1'b0;

    // Combinational vector table in RUN with no memory access.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      rs1d = vt[i].rs1d; rs2d = vt[i].rs2d; rs1e = vt[i].rs1e; rs2e = vt[i].rs2e;
      rde = vt[i].rde; rdm = vt[i].rdm; rdw = vt[i].rdw;
      regwritem = vt[i].rwm; regwritew = vt[i].rww; loade = vt[i].lde; pcsrce = vt[i].br;
      #1;
      chk($sformatf("vec%0d.fae", i), 32'(forwardae), 32'(vt[i].fae));
      chk($sformatf("vec%0d.fbe", i), 32'(forwardbe), 32'(vt[i].fbe));
      chk_ctl($sformatf("vec%0d", i), vt[i].pce, vt[i].ife, 1'b1, vt[i].ifc, vt[i].idc);
    end

    // Single-cycle load-use stall: stall_cnt 0 -> 1.
    idle_inputs();
    do_reset();
    loade = 1'b1; rde = 5'd7; rs2d = 5'd7;
    #1;
    chk_ctl("lw", 0, 0, 1, 0, 1);
    chk("lw.cnt0", 32'(stall_cnt), 32'd0);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("lw.cnt1", 32'(stall_cnt), 32'd1);
    chk_ctl("lw.after", 1, 1, 1, 0, 0);

    // Memory wait of 3 cycles with a taken branch held in Execute.
    do_reset();
    dmem_req = 1'b1; pcsrce = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk_ctl($sformatf("wait%0d", c), 0, 0, 0, 0, 0);
      @(negedge clk);
    end
    dmem_ack = 1'b1;
    #1;
    chk_ctl("ack", 1, 1, 1, 1, 1);
    chk("ack.stall_cnt", 32'(stall_cnt), 32'd3);
    @(negedge clk);
    // Request acked in the same cycle: no freeze, stays in RUN.
    pcsrce = 1'b0;
    #1;
    chk_ctl("reqack", 1, 1, 1, 0, 0);
    @(negedge clk);
    dmem_req = 1'b0; dmem_ack = 1'b0;
    #1;
    chk_ctl("run.after", 1, 1, 1, 0, 0);
    chk("run.stall_cnt", 32'(stall_cnt), 32'd3);

    // Timeout with TIMEOUT=4: request cycle plus five WAIT cycles, then ERR.
    do_reset();
    dmem_req = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("to.before", 32'(mem_err), 32'd0);
    @(posedge clk);
    #1;
    chk("to.mem_err", 32'(mem_err), 32'd1);
    @(negedge clk);
    dmem_ack = 1'b1;
    #1;
    chk_ctl("err.frozen", 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("err.sticky", 32'(mem_err), 32'd1);
    #2;
    dmem_req = 1'b0; dmem_ack = 1'b0;
    reset = 1'b1;
    #1;
    chk("err.rst.mem_err", 32'(mem_err), 32'd0);
    chk_ctl("err.rst", 1, 1, 1, 0, 0);
    @(negedge clk);
    reset = 1'b0;

    // Saturation of the 3-bit stall counter.
    loade = 1'b1; rde = 5'd7; rs1d = 5'd7;
    repeat (9) @(negedge clk);
    chk("sat.stall_cnt", 32'(stall_cnt), 32'd7);
    idle_inputs();

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got %0d/%0d", npass, ntotal);
    $fatal(1);
  end

endmodule
